// File: rtl/ring_osc_sequencer.sv
// ring_osc_sequencer
//   Sequencer for the free-running inverter-chain oscillator. Enables the
//   chain, lets it settle, counts rising edges of a chain tap over a latched
//   window of clk cycles, flushes the synchroniser, then pulses done with the
//   result. This block is the only driver of the ring enable.
//
// Ports
//   clk       in   system clock
//   rst_n     in   asynchronous active-low reset
//   start     in   run request, sampled only while idle
//   abort     in   cancel the current run, overrides start
//   window    in   measurement length in clk cycles, latched on accepted start
//   ring_out  in   asynchronous oscillator tap
//   ring_en   out  registered enable to the oscillator chain
//   busy      out  run in progress (settle, measure, drain)
//   done      out  one-cycle pulse, count/overflow valid
//   count     out  rising edges seen in the window, held until next start
//   overflow  out  an edge arrived while count was already saturated
module ring_osc_sequencer #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned WIN_W       = 16,
  parameter int unsigned SETTLE_CYC  = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [WIN_W-1:0] window,
  input  logic             ring_out,
  output logic             ring_en,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] count,
  output logic             overflow
);

  // One timer is shared by settle, measure and drain phases, so it must
  // hold the largest of the three reload values.
  localparam int unsigned SET_W = $clog2(SETTLE_CYC + 1);
  localparam int unsigned SYN_W = $clog2(SYNC_STAGES + 1);
  localparam int unsigned TMR_A = (WIN_W > SET_W) ? WIN_W : SET_W;
  localparam int unsigned TMR_W = (TMR_A > SYN_W) ? TMR_A : SYN_W;

  localparam logic [TMR_W-1:0] SETTLE_LD = TMR_W'(SETTLE_CYC - 1);
  localparam logic [TMR_W-1:0] DRAIN_LD  = TMR_W'(SYNC_STAGES - 1);
  localparam logic [TMR_W-1:0] TMR_ONE   = TMR_W'(1);

  typedef enum logic [2:0] {IDLE, SETTLE, MEASURE, DRAIN, DONE} state_e;

  state_e                 state_q, state_d;
  logic [TMR_W-1:0]       timer_q, timer_d;
  logic [WIN_W-1:0]       win_q, win_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   ovf_q, ovf_d;
  logic                   ring_en_q, ring_en_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   rise;

  // Synchroniser and edge detector run continuously in every state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], ring_out};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      win_q     <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      ring_en_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      win_q     <= win_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      ring_en_q <= ring_en_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    win_d   = win_q;
    count_d = count_q;
    ovf_d   = ovf_q;

    if (abort) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_d = SETTLE;
            win_d   = window;
            count_d = '0;
            ovf_d   = 1'b0;
            timer_d = SETTLE_LD;
          end
        end
        SETTLE: begin
          if (timer_q == '0) begin
            if (win_q == '0) begin
              state_d = DRAIN;
              timer_d = DRAIN_LD;
            end else begin
              state_d = MEASURE;
              timer_d = TMR_W'(win_q) - TMR_ONE;
            end
          end else begin
            timer_d = timer_q - TMR_ONE;
          end
        end
        MEASURE: begin
          if (rise) begin
            if (count_q == '1) ovf_d = 1'b1;
            else               count_d = count_q + CNT_W'(1);
          end
          if (timer_q == '0) begin
            state_d = DRAIN;
            timer_d = DRAIN_LD;
          end else begin
            timer_d = timer_q - TMR_ONE;
          end
        end
        DRAIN: begin
          if (timer_q == '0) state_d = DONE;
          else               timer_d = timer_q - TMR_ONE;
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end

    // Status outputs are decoded from the next state so they are flops that
    // line up with the state they describe.
    ring_en_d = (state_d == SETTLE) || (state_d == MEASURE);
    busy_d    = (state_d == SETTLE) || (state_d == MEASURE) || (state_d == DRAIN);
    done_d    = (state_d == DONE);
  end

  assign ring_en  = ring_en_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign count    = count_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_ring_osc_sequencer.sv
// tb_ring_osc_sequencer
//   Drives two sequencer instances (16-bit and 3-bit counters) with identical
//   stimulus and compares them against a run-timeline and edge-count model.
module tb_ring_osc_sequencer;

  localparam int S  = 4;
  localparam int NS = 2;

  logic        clk      = 1'b0;
  logic        rst_n    = 1'b0;
  logic        start    = 1'b0;
  logic        abort    = 1'b0;
  logic        ring_out = 1'b0;
  logic [15:0] window   = '0;

  logic        ring_en, busy, done, overflow;
  logic [15:0] count;
  logic        ring_en3, busy3, done3, overflow3;
  logic [2:0]  count3;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit rhist [0:8191];

  always #5 clk = ~clk;

  ring_osc_sequencer #(.CNT_W(16), .WIN_W(16), .SETTLE_CYC(S), .SYNC_STAGES(NS)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .window(window),
    .ring_out(ring_out), .ring_en(ring_en), .busy(busy), .done(done),
    .count(count), .overflow(overflow)
  );

  ring_osc_sequencer #(.CNT_W(3), .WIN_W(16), .SETTLE_CYC(S), .SYNC_STAGES(NS)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .window(window),
    .ring_out(ring_out), .ring_en(ring_en3), .busy(busy3), .done(done3),
    .count(count3), .overflow(overflow3)
  );

  // ring_out value r is held for the cycle that starts now; advance one clock.
  task automatic step(input bit r);
    ring_out   = r;
    rhist[cyc] = r;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Rising edges of ring_out as seen NS cycles late, over cycles lo..hi.
  function automatic int edges_in(input int lo, input int hi);
    int n = 0;
    for (int k = lo; k <= hi; k++)
      if (rhist[k-NS] && !rhist[k-NS-1]) n++;
    return n;
  endfunction

  // {ring_en, busy, done} in cycle j of a run with window w.
  function automatic logic [2:0] flags(input int j, input int w);
    return {(j >= 1 && j <= S + w), (j >= 1 && j <= S + w + NS), (j == S + w + NS + 1)};
  endfunction

  function automatic int sat3(input int e);
    return (e > 7) ? 7 : e;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    checks++;
    if ({ring_en, busy, done, overflow} !== 4'b0 || count !== 16'd0) begin
      failures++;
      $display("FAIL reset16 got=%b/%0d exp=0000/0", {ring_en, busy, done, overflow}, count);
    end
    checks++;
    if ({ring_en3, busy3, done3, overflow3} !== 4'b0 || count3 !== 3'd0) begin
      failures++;
      $display("FAIL reset3 got=%b/%0d exp=0000/0", {ring_en3, busy3, done3, overflow3}, count3);
    end
    repeat (3) step(1'b0);
    rst_n = 1'b1;
    repeat (3) begin
      step(1'b0);
      checks++;
      if ({ring_en, busy, done, ring_en3, busy3, done3} !== 6'b0) begin
        failures++;
        $display("FAIL idle_after_reset cyc=%0d got=%b exp=000000", cyc,
                 {ring_en, busy, done, ring_en3, busy3, done3});
      end
    end
  endtask

  task automatic test_run(input string name, input int w, input bit rnd);
    int a, L, e;
    logic [2:0] ex;
    L = S + w + NS + 1;
    e = 0;
    window = 16'(w);
    start  = 1'b1;
    a      = cyc;
    step(rnd ? 1'($urandom) : 1'b0);
    start  = 1'b0;
    window = 16'($urandom);
    for (int j = 1; j <= L + 1; j++) begin
      ex = flags(j, w);
      checks++;
      if ({ring_en, busy, done} !== ex) begin
        failures++;
        $display("FAIL %s_flags16 j=%0d got=%b exp=%b", name, j, {ring_en, busy, done}, ex);
      end
      checks++;
      if ({ring_en3, busy3, done3} !== ex) begin
        failures++;
        $display("FAIL %s_flags3 j=%0d got=%b exp=%b", name, j, {ring_en3, busy3, done3}, ex);
      end
      if (j <= S) begin
        checks++;
        if (count !== 16'd0 || overflow !== 1'b0 || count3 !== 3'd0 || overflow3 !== 1'b0) begin
          failures++;
          $display("FAIL %s_cleared j=%0d got=%0d/%b %0d/%b exp=0/0 0/0", name, j,
                   count, overflow, count3, overflow3);
        end
      end
      if (j == L) e = edges_in(a + S + 1, a + S + w);
      if (j >= L) begin
        checks++;
        if (count !== 16'(e) || overflow !== 1'b0) begin
          failures++;
          $display("FAIL %s_count16 j=%0d got=%0d/%b exp=%0d/0", name, j, count, overflow, e);
        end
        checks++;
        if (count3 !== 3'(sat3(e)) || overflow3 !== (e > 7)) begin
          failures++;
          $display("FAIL %s_count3 j=%0d got=%0d/%b exp=%0d/%b", name, j, count3, overflow3,
                   sat3(e), (e > 7));
        end
      end
      step(rnd ? 1'($urandom) : 1'(j % 2));
    end
  endtask

  task automatic test_abort();
    int a, p;
    logic [2:0] ex;
    window = 16'd10;
    start  = 1'b1;
    a      = cyc;
    step(1'b0);
    start  = 1'b0;
    for (int j = 1; j <= 8; j++) begin
      ex = flags(j, 10);
      checks++;
      if ({ring_en, busy, done, ring_en3, busy3, done3} !== {ex, ex}) begin
        failures++;
        $display("FAIL abort_pre j=%0d got=%b exp=%b", j, {ring_en, busy, done, ring_en3, busy3, done3}, {ex, ex});
      end
      if (j == 8) abort = 1'b1;
      step(1'(j % 2));
    end
    abort = 1'b0;
    p = edges_in(a + S + 1, a + 7);
    for (int j = 9; j <= 24; j++) begin
      checks++;
      if ({ring_en, busy, done, ring_en3, busy3, done3} !== 6'b0) begin
        failures++;
        $display("FAIL abort_idle j=%0d got=%b exp=000000", j, {ring_en, busy, done, ring_en3, busy3, done3});
      end
      checks++;
      if (count !== 16'(p) || overflow !== 1'b0 || count3 !== 3'(sat3(p))) begin
        failures++;
        $display("FAIL abort_partial j=%0d got=%0d/%b/%0d exp=%0d/0/%0d", j, count, overflow, count3, p, sat3(p));
      end
      step(1'($urandom));
    end
    start = 1'b1;
    abort = 1'b1;
    step(1'b0);
    start = 1'b0;
    abort = 1'b0;
    checks++;
    if ({ring_en, busy, ring_en3, busy3} !== 4'b0) begin
      failures++;
      $display("FAIL abort_over_start got=%b exp=0000", {ring_en, busy, ring_en3, busy3});
    end
    test_run("abort_restart", 6, 1'b1);
  endtask

  task automatic test_reset_mid();
    int a, p;
    logic [2:0] ex;
    window = 16'd10;
    start  = 1'b1;
    a      = cyc;
    step(1'b0);
    start  = 1'b0;
    for (int j = 1; j <= 8; j++) begin
      ex = flags(j, 10);
      checks++;
      if ({ring_en, busy, done} !== ex) begin
        failures++;
        $display("FAIL rstmid_pre j=%0d got=%b exp=%b", j, {ring_en, busy, done}, ex);
      end
      step(1'(j % 2));
    end
    p = edges_in(a + S + 1, a + 8);
    checks++;
    if (count !== 16'(p)) begin
      failures++;
      $display("FAIL rstmid_partial got=%0d exp=%0d", count, p);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({ring_en, busy, done, overflow} !== 4'b0 || count !== 16'd0 ||
        {ring_en3, busy3, done3, overflow3} !== 4'b0 || count3 !== 3'd0) begin
      failures++;
      $display("FAIL rstmid_async got=%b/%0d %b/%0d exp=0000/0 0000/0",
               {ring_en, busy, done, overflow}, count, {ring_en3, busy3, done3, overflow3}, count3);
    end
    repeat (3) begin
      step(1'b0);
      checks++;
      if ({ring_en, busy, done, ring_en3, busy3, done3} !== 6'b0 || count !== 16'd0) begin
        failures++;
        $display("FAIL rstmid_held got=%b/%0d exp=000000/0", {ring_en, busy, done, ring_en3, busy3, done3}, count);
      end
    end
    rst_n = 1'b1;
    step(1'b0);
    step(1'b0);
    test_run("after_reset", 10, 1'b0);
  endtask

  task automatic test_back_to_back();
    int w [3];
    int a, L, e;
    logic [2:0] ex;
    for (int i = 0; i < 3; i++) w[i] = $urandom_range(0, 12);
    start  = 1'b1;
    window = 16'(w[0]);
    for (int r = 0; r < 3; r++) begin
      a = cyc;
      L = S + w[r] + NS + 1;
      e = 0;
      step(1'($urandom));
      window = 16'($urandom);
      for (int j = 1; j <= L; j++) begin
        ex = flags(j, w[r]);
        checks++;
        if ({ring_en, busy, done, ring_en3, busy3, done3} !== {ex, ex}) begin
          failures++;
          $display("FAIL b2b_flags run=%0d j=%0d got=%b exp=%b", r, j,
                   {ring_en, busy, done, ring_en3, busy3, done3}, {ex, ex});
        end
        if (j == L) begin
          e = edges_in(a + S + 1, a + S + w[r]);
          checks++;
          if (count !== 16'(e) || count3 !== 3'(sat3(e)) || overflow3 !== (e > 7)) begin
            failures++;
            $display("FAIL b2b_count run=%0d got=%0d/%0d/%b exp=%0d/%0d/%b", r, count, count3,
                     overflow3, e, sat3(e), (e > 7));
          end
        end
        if (j == L - 1 && r < 2) window = 16'(w[r+1]);
        step(1'($urandom));
      end
      checks++;
      if ({ring_en, busy, done, ring_en3, busy3, done3} !== 6'b0 || count !== 16'(e)) begin
        failures++;
        $display("FAIL b2b_idle_gap run=%0d got=%b/%0d exp=000000/%0d", r,
                 {ring_en, busy, done, ring_en3, busy3, done3}, count, e);
      end
      if (r == 2) start = 1'b0;
    end
    repeat (4) begin
      step(1'($urandom));
      checks++;
      if ({busy, busy3, done, done3} !== 4'b0) begin
        failures++;
        $display("FAIL b2b_stop got=%b exp=0000", {busy, busy3, done, done3});
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) begin
      repeat ($urandom_range(0, 3)) step(1'($urandom));
      test_run("random", $urandom_range(0, 30), 1'b1);
    end
  endtask

  initial begin
    test_reset();
    test_run("basic", 10, 1'b0);
    test_run("zero_win", 0, 1'b0);
    test_run("sat", 40, 1'b0);
    test_abort();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
    $fatal(1);
  end

endmodule
